uart_tx_periph: RTL and testbench

//  Memory-mapped UART transmitter on the CPU data bus, beside the GPIO register.
//  The SoC decodes a base address and drives sel; CPU stores push bytes into a TX FIFO.
//  A bit-timer FSM serialises each byte as 8N1 (LSB first) on the tx pin.

---
 rtl/uart_tx_periph.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// ---------------------------------------------------------------------------
// uart_tx_periph
//   Memory-mapped 8N1 UART transmitter. CPU stores to DATA push bytes into a
//   small circular FIFO; a bit-timer FSM pops them and shifts them out LSB
//   first on tx. Firmware polls STATUS before writing.
//
//   Register map (addr[3:2]):
//     0 DATA     W: push wdata[7:0]            R: 0
//     1 STATUS   R: [0] busy [1] full [2] empty [3] overflow [7:4] count
//                W: any write clears overflow
//     2 DIVISOR  R/W [15:0] clocks per bit (0 and 1 stored as 2)
//     3 reserved R: 0, W: ignored
//
// Ports
//   clk     system clock
//   resetn  asynchronous active-low reset
//   sel     peripheral selected by SoC address decode
//   addr    byte address, only addr[3:2] decoded
//   ren     read strobe (qualified with sel)
//   rdata   registered read data
//   wen     write strobe (qualified with sel)
//   wdata   write data
//   wsize   store size, unused
//   tx      serial output, idle high
//
// FSM states
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | line idle high, waiting for FIFO data
//   S_START | start bit (low) for one bit time
//   S_DATA  | eight data bits, LSB first, bit_idx selects position
//   S_STOP  | stop bit (high); chains straight into next START if data
// ---------------------------------------------------------------------------
module uart_tx_periph #(
  parameter int DIV_RESET = 16,
  parameter int FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic        ren,
  output logic [31:0] rdata,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [1:0]  wsize,
  output logic        tx
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bits of the bus that carry no meaning for this block.
  logic unused_bus;
  assign unused_bus = ^{addr[31:4], addr[1:0], wsize, wdata[31:16]};

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic       wr_en;
  logic       rd_en;
  logic [1:0] reg_sel;
  logic       push_req;

  assign wr_en    = sel & wen;
  assign rd_en    = sel & ren;
  assign reg_sel  = addr[3:2];
  assign push_req = wr_en && (reg_sel == 2'd0);

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  assign full  = (count == (FIFO_AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // accepted in that case. When full, wr_ptr == rd_ptr: the pop reads the
  // old head while the push overwrites that slot.
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  logic [15:0] divisor;
  logic        overflow;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divisor  <= 16'(DIV_RESET);
      overflow <= 1'b0;
    end else begin
      if (wr_en && (reg_sel == 2'd2)) begin
        divisor <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
      end
      if (wr_en && (reg_sel == 2'd1)) begin
        overflow <= 1'b0;
      end else if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  state_t      state;
  state_t      state_nxt;
  logic [15:0] timer;
  logic [15:0] div_frame;   // divisor captured at frame start
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        tc;
  logic        tx_nxt;

  assign tc = (timer == 16'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_START;
      S_START: if (tc) state_nxt = S_DATA;
      S_DATA:  if (tc && (bit_idx == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (tc) state_nxt = empty ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    tx_nxt = tx;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!empty) begin
          pop    = 1'b1;
          tx_nxt = 1'b0;
        end
      end
      S_START: if (tc) tx_nxt = shift[0];
      S_DATA:  if (tc) tx_nxt = (bit_idx == 3'd7) ? 1'b1 : shift[1];
      S_STOP: begin
        if (tc && !empty) begin
          pop    = 1'b1;
          tx_nxt = 1'b0;
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx        <= 1'b1;
      timer     <= '0;
      div_frame <= '0;
      shift     <= '0;
      bit_idx   <= '0;
    end else begin
      tx <= tx_nxt;
      if (pop) begin
        shift     <= fifo_mem[rd_ptr];
        div_frame <= divisor;
        timer     <= divisor - 16'd1;
        bit_idx   <= '0;
      end else if (state != S_IDLE) begin
        if (tc) begin
          timer <= div_frame - 16'd1;
          if (state == S_DATA) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          timer <= timer - 16'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  logic [3:0]  count_disp;
  logic [31:0] rd_mux;

  always_comb begin
    count_disp = 4'hF;
    if (32'(count) < 32'd16) count_disp = 4'(count);
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd1:    rd_mux = {24'd0, count_disp, overflow, empty, full, state != S_IDLE};
      2'd2:    rd_mux = {16'd0, divisor};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    rdata <= '0;
    else if (rd_en) rdata <= rd_mux;
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_periph
//   Directed bench for uart_tx_periph. Inputs change on the falling edge,
//   outputs are sampled on the falling edge. Frames are captured bit by bit
//   and compared against {stop, byte, start}.
// ---------------------------------------------------------------------------
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel;
  logic [31:0] addr;
  logic        ren;
  logic [31:0] rdata;
  logic        wen;
  logic [31:0] wdata;
  logic [1:0]  wsize;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] A_DATA = 32'h0000_0000;
  localparam logic [31:0] A_STAT = 32'h0000_0004;
  localparam logic [31:0] A_DIV  = 32'h4000_0008;
  localparam logic [31:0] A_RSVD = 32'h0000_000C;

  uart_tx_periph #(.DIV_RESET(16), .FIFO_AW(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sel    (sel),
    .addr   (addr),
    .ren    (ren),
    .rdata  (rdata),
    .wen    (wen),
    .wdata  (wdata),
    .wsize  (wsize),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus tasks are entered at a falling edge and return at the next one.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sel = 1'b1; wen = 1'b1; addr = a; wdata = d; wsize = 2'b10;
    @(negedge clk);
    sel = 1'b0; wen = 1'b0; wsize = 2'b00;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic s, output logic [31:0] d);
    sel = s; ren = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; ren = 1'b0;
    d = rdata;
  endtask

  // Entered at the falling edge just before the pop edge. Records the first
  // sample of each bit and whether every sample of each bit matched it.
  task automatic capture_frame(input int div, output logic [9:0] bits, output logic steady);
    bits   = '0;
    steady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < div; s++) begin
        @(negedge clk);
        if (s == 0) bits[i] = tx;
        else if (tx !== bits[i]) steady = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    resetn = 1'b0; sel = 1'b0; ren = 1'b0; wen = 1'b0;
    addr = '0; wdata = '0; wsize = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    resetn = 1'b1;
    @(negedge clk);
    bus_read(A_STAT, 1'b1, rd);
    n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL reset_status: got %h expected 04", rd); end
    bus_read(A_DIV, 1'b1, rd);
    n_checks++; if (rd !== 32'd16) begin n_fail++; $display("FAIL reset_divisor: got %0d expected 16", rd); end
  endtask

  task automatic test_basic_frame();
    logic [31:0] rd;
    logic [9:0]  fr;
    logic        ok;
    bus_write(A_DATA, 32'hFFFF_FF55);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL basic_pre_tx: got %b expected 1", tx); end
    capture_frame(16, fr, ok);
    n_checks++; if (fr !== 10'b1_01010101_0) begin n_fail++; $display("FAIL basic_frame: got %b expected %b", fr, 10'b1_01010101_0); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_bit_width: got %b expected 1", ok); end
    @(negedge clk);
    bus_read(A_STAT, 1'b1, rd);
    n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL basic_idle_status: got %h expected 04", rd); end
  endtask

  task automatic test_divisor();
    logic [31:0] rd;
    logic [9:0]  fr;
    logic        ok;
    bus_write(A_DIV, 32'h0);
    bus_read(A_DIV, 1'b1, rd);
    n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL div_zero: got %0d expected 2", rd); end
    bus_write(A_DIV, 32'h1);
    bus_read(A_DIV, 1'b1, rd);
    n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL div_one: got %0d expected 2", rd); end
    bus_write(A_DIV, 32'hABCD_0004);
    bus_read(A_DIV, 1'b1, rd);
    n_checks++; if (rd !== 32'd4) begin n_fail++; $display("FAIL div_four: got %0d expected 4", rd); end
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    bus_read(A_RSVD, 1'b1, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rsvd_read: got %h expected 0", rd); end
    bus_read(A_DATA, 1'b1, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL data_read: got %h expected 0", rd); end
    bus_write(A_DATA, 32'h0000_00A3);
    capture_frame(4, fr, ok);
    // 0xA3 LSB first: 1,1,0,0,0,1,0,1
    n_checks++; if (fr !== 10'b1_10100011_0) begin n_fail++; $display("FAIL div4_frame: got %b expected %b", fr, 10'b1_10100011_0); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL div4_bit_width: got %b expected 1", ok); end
    @(negedge clk);
    bus_read(A_STAT, 1'b1, rd);
    n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL div4_idle_status: got %h expected 04", rd); end
  endtask

  task automatic test_overflow();
    logic [7:0]  tbl [8];
    logic [7:0]  exp_b [9];
    logic [9:0]  fr [9];
    logic        ok [9];
    logic [31:0] st_full, st_ovf, st_clr, rd;
    tbl = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'hFF, 8'h7E};
    exp_b[0] = 8'hF0;
    for (int i = 0; i < 8; i++) exp_b[i+1] = tbl[i];
    fork
      begin
        bus_write(A_DATA, 32'h0000_00F0);
        for (int i = 0; i < 8; i++) bus_write(A_DATA, {24'h0, tbl[i]});
        bus_read(A_STAT, 1'b1, st_full);
        bus_write(A_DATA, 32'h0000_00EE);
        bus_read(A_STAT, 1'b1, st_ovf);
        bus_write(A_STAT, 32'h0);
        bus_read(A_STAT, 1'b1, st_clr);
      end
      begin
        @(negedge clk);
        for (int f = 0; f < 9; f++) capture_frame(4, fr[f], ok[f]);
      end
    join
    n_checks++; if (st_full !== 32'h83) begin n_fail++; $display("FAIL ovf_full_status: got %h expected 83", st_full); end
    n_checks++; if (st_ovf !== 32'h8B) begin n_fail++; $display("FAIL ovf_set_status: got %h expected 8b", st_ovf); end
    n_checks++; if (st_clr !== 32'h83) begin n_fail++; $display("FAIL ovf_clear_status: got %h expected 83", st_clr); end
    for (int f = 0; f < 9; f++) begin
      n_checks++;
      if (fr[f] !== {1'b1, exp_b[f], 1'b0}) begin
        n_fail++; $display("FAIL ovf_frame%0d: got %b expected %b", f, fr[f], {1'b1, exp_b[f], 1'b0});
      end
      n_checks++; if (ok[f] !== 1'b1) begin n_fail++; $display("FAIL ovf_bit_width%0d: got %b expected 1", f, ok[f]); end
    end
    @(negedge clk);
    bus_read(A_STAT, 1'b1, rd);
    n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL ovf_drained_status: got %h expected 04", rd); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0]  tbl [8];
    logic [7:0]  exp_b [10];
    logic [9:0]  fr [10];
    logic        ok [10];
    logic [31:0] st, rd;
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_b[0] = 8'h96;
    for (int i = 0; i < 8; i++) exp_b[i+1] = tbl[i];
    exp_b[9] = 8'h69;
    fork
      begin
        bus_write(A_DATA, 32'h0000_0096);
        for (int i = 0; i < 8; i++) bus_write(A_DATA, {24'h0, tbl[i]});
        // Land the next push exactly on the STOP-end pop of the first frame.
        repeat (32) @(negedge clk);
        bus_write(A_DATA, 32'h0000_0069);
        bus_read(A_STAT, 1'b1, st);
      end
      begin
        @(negedge clk);
        for (int f = 0; f < 10; f++) capture_frame(4, fr[f], ok[f]);
      end
    join
    n_checks++; if (st !== 32'h83) begin n_fail++; $display("FAIL pushpop_status: got %h expected 83", st); end
    for (int f = 0; f < 10; f++) begin
      n_checks++;
      if (fr[f] !== {1'b1, exp_b[f], 1'b0}) begin
        n_fail++; $display("FAIL pushpop_frame%0d: got %b expected %b", f, fr[f], {1'b1, exp_b[f], 1'b0});
      end
      n_checks++; if (ok[f] !== 1'b1) begin n_fail++; $display("FAIL pushpop_bit_width%0d: got %b expected 1", f, ok[f]); end
    end
    @(negedge clk);
    bus_read(A_STAT, 1'b1, rd);
    n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL pushpop_drained_status: got %h expected 04", rd); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    logic        stayed_high;
    bus_write(A_DATA, 32'h0000_0000);
    bus_write(A_DATA, 32'h0000_0011);
    repeat (5) @(negedge clk);
    n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL midreset_pre_tx: got %b expected 0", tx); end
    resetn = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midreset_tx: got %b expected 1", tx); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_rdata: got %h expected 0", rdata); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    bus_read(A_STAT, 1'b1, rd);
    n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL midreset_status: got %h expected 04", rd); end
    bus_read(A_DIV, 1'b1, rd);
    n_checks++; if (rd !== 32'd16) begin n_fail++; $display("FAIL midreset_divisor: got %0d expected 16", rd); end
    stayed_high = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) stayed_high = 1'b0;
    end
    n_checks++; if (stayed_high !== 1'b1) begin n_fail++; $display("FAIL midreset_idle_line: got %b expected 1", stayed_high); end
  endtask

  task automatic test_div_change();
    logic [9:0]  fr0, fr1;
    logic        ok0, ok1;
    logic [31:0] s_stat, s_nosel, s_div, rd;
    fork
      begin
        bus_write(A_DATA, 32'h0000_003C);
        bus_write(A_DATA, 32'h0000_00C5);
        repeat (10) @(negedge clk);
        bus_write(A_DIV, 32'h0000_0008);
        bus_read(A_STAT, 1'b1, s_stat);
        bus_read(A_DIV, 1'b0, s_nosel);
        bus_read(A_DIV, 1'b1, s_div);
      end
      begin
        @(negedge clk);
        capture_frame(16, fr0, ok0);
        capture_frame(8, fr1, ok1);
      end
    join
    n_checks++; if (s_stat !== 32'h11) begin n_fail++; $display("FAIL divchg_status: got %h expected 11", s_stat); end
    n_checks++; if (s_nosel !== 32'h11) begin n_fail++; $display("FAIL divchg_nosel_hold: got %h expected 11", s_nosel); end
    n_checks++; if (s_div !== 32'd8) begin n_fail++; $display("FAIL divchg_readback: got %0d expected 8", s_div); end
    n_checks++; if (fr0 !== 10'b1_00111100_0) begin n_fail++; $display("FAIL divchg_frame16: got %b expected %b", fr0, 10'b1_00111100_0); end
    n_checks++; if (ok0 !== 1'b1) begin n_fail++; $display("FAIL divchg_width16: got %b expected 1", ok0); end
    n_checks++; if (fr1 !== 10'b1_11000101_0) begin n_fail++; $display("FAIL divchg_frame8: got %b expected %b", fr1, 10'b1_11000101_0); end
    n_checks++; if (ok1 !== 1'b1) begin n_fail++; $display("FAIL divchg_width8: got %b expected 1", ok1); end
    @(negedge clk);
    bus_read(A_STAT, 1'b1, rd);
    n_checks++; if (rd !== 32'h04) begin n_fail++; $display("FAIL divchg_idle_status: got %h expected 04", rd); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_divisor();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_frame();
    test_div_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
